// File: rtl/product_accumulator.sv
// product_accumulator
//   Buffers unsigned products from a shift-and-add multiplier in a 4-entry
//   FIFO and sums them into a saturating accumulator. A dump request drains
//   the FIFO and then presents the total on a valid/ready output.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   prod_valid : prod carries a product this cycle
//   prod       : unsigned product, PW bits
//   dump       : request to emit the running total (honoured in ACC only)
//   clr        : synchronous clear of accumulation, FIFO and sticky flags
//   out_ready  : consumer accepts acc_out
//   acc_out    : accumulated total while out_valid, else 0
//   out_valid  : acc_out is valid
//   prod_count : products accumulated, saturating at 255
//   overflow   : sticky, accumulator saturated
//   dropped    : sticky, product lost to a full FIFO
//   busy       : not in ACC, or FIFO non-empty
module product_accumulator #(
    parameter int unsigned PW = 16,
    parameter int unsigned AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prod_valid,
    input  logic [PW-1:0] prod,
    input  logic          dump,
    input  logic          clr,
    input  logic          out_ready,
    output logic [AW-1:0] acc_out,
    output logic          out_valid,
    output logic [7:0]    prod_count,
    output logic          overflow,
    output logic          dropped,
    output logic          busy
);

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       r_acc_out;
    logic                r_out_valid;
    logic [7:0]          r_prod_count;
    logic                r_overflow;
    logic                r_dropped;
    logic                r_busy;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [AW:0]         w_sum;
    logic [AW-1:0]       w_acc_sat;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_count_nxt;

    // FIFO handshake: a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(FIFO_DEPTH));
        w_pop   = !clr && (r_state != ST_EMIT) && !w_empty;
        w_push  = !clr && prod_valid && (!w_full || w_pop);
        w_drop  = !clr && prod_valid && w_full && !w_pop;
    end

    // Saturating add of the FIFO head; the carry bit flags overflow
    always_comb begin
        w_sum     = {1'b0, r_acc} + (AW+1)'(r_mem[r_rd_ptr]);
        w_acc_sat = w_sum[AW] ? '1 : w_sum[AW-1:0];
    end

    // Next state and occupancy, shared by the FSM and the registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (clr) begin
            w_state_nxt = ST_ACC;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_ACC:   if (dump)      w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_empty)   w_state_nxt = ST_EMIT;
                ST_EMIT:  if (out_ready) w_state_nxt = ST_ACC;
                default:                 w_state_nxt = ST_ACC;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= prod;
        end
    end

    // FSM, accumulator, pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ACC;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_acc        <= '0;
            r_acc_out    <= '0;
            r_out_valid  <= 1'b0;
            r_prod_count <= '0;
            r_overflow   <= 1'b0;
            r_dropped    <= 1'b0;
            r_busy       <= 1'b0;
        end else if (clr) begin
            r_state      <= ST_ACC;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_acc        <= '0;
            r_acc_out    <= '0;
            r_out_valid  <= 1'b0;
            r_prod_count <= '0;
            r_overflow   <= 1'b0;
            r_dropped    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_acc    <= w_acc_sat;
                if (w_sum[AW]) begin
                    r_overflow <= 1'b1;
                end
                if (r_prod_count != 8'hFF) begin
                    r_prod_count <= r_prod_count + 8'd1;
                end
            end
            // Handshake edge; no pop can coincide since EMIT never pops
            if ((r_state == ST_EMIT) && out_ready) begin
                r_acc        <= '0;
                r_prod_count <= '0;
                r_overflow   <= 1'b0;
            end
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
            // acc is frozen on entry to and throughout EMIT
            r_out_valid <= (w_state_nxt == ST_EMIT);
            r_acc_out   <= (w_state_nxt == ST_EMIT) ? r_acc : '0;
            r_busy      <= (w_state_nxt != ST_ACC) || (w_count_nxt != '0);
        end
    end

    assign acc_out    = r_acc_out;
    assign out_valid  = r_out_valid;
    assign prod_count = r_prod_count;
    assign overflow   = r_overflow;
    assign dropped    = r_dropped;
    assign busy       = r_busy;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: transaction-level reference model
// compared every negative edge, plus directed scenarios with literal results.
module tb_product_accumulator;

    localparam int unsigned PW = 16;
    localparam int unsigned AW = 24;
    localparam longint MAXV = (64'd1 << AW) - 1;

    logic          clk;
    logic          rst;
    logic          prod_valid;
    logic [PW-1:0] prod;
    logic          dump;
    logic          clr;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic          out_valid;
    logic [7:0]    prod_count;
    logic          overflow;
    logic          dropped;
    logic          busy;

    product_accumulator #(.PW(PW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod       (prod),
        .dump       (dump),
        .clr        (clr),
        .out_ready  (out_ready),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .prod_count (prod_count),
        .overflow   (overflow),
        .dropped    (dropped),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a queue of pending products and a phase
    // (0 accumulating, 1 draining, 2 presenting the total)
    int     mq[$];
    longint m_acc;
    int     m_cnt;
    bit     m_ovf;
    bit     m_drop;
    int     m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_acc = 0; m_cnt = 0; m_ovf = 0; m_drop = 0; m_phase = 0;
    endtask

    task automatic model_step();
        bit was_empty;
        bit do_pop;
        bit accept;
        longint s;
        if (rst) begin
            model_reset();
            return;
        end
        if (clr) begin
            model_reset();
            return;
        end
        was_empty = (mq.size() == 0);
        do_pop    = (m_phase != 2) && !was_empty;
        accept    = prod_valid && ((mq.size() < 4) || do_pop);
        if (prod_valid && !accept) m_drop = 1;
        if (do_pop) begin
            s = m_acc + longint'(mq.pop_front());
            if (s > MAXV) begin
                m_acc = MAXV;
                m_ovf = 1;
            end else begin
                m_acc = s;
            end
            if (m_cnt < 255) m_cnt++;
        end
        if (accept) mq.push_back(int'(prod));
        case (m_phase)
            0: if (dump) m_phase = 1;
            1: if (was_empty) m_phase = 2;
            default: if (out_ready) begin
                m_acc = 0; m_cnt = 0; m_ovf = 0; m_phase = 0;
            end
        endcase
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid",  32'(out_valid),  32'(m_phase == 2));
            check("acc_out",    32'(acc_out),    (m_phase == 2) ? 32'(m_acc) : 32'd0);
            check("prod_count", 32'(prod_count), 32'(m_cnt));
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("dropped",    32'(dropped),    32'(m_drop));
            check("busy",       32'(busy),       32'((m_phase != 0) || (mq.size() != 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic push(input logic [PW-1:0] v);
        prod_valid = 1'b1;
        prod       = v;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic do_dump();
        dump = 1'b1;
        tick();
        dump = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prod_valid = 1'b0; prod = '0; dump = 1'b0;
        clr = 1'b0; out_ready = 1'b0;
        model_reset();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);

        // Single product
        push(16'd65025);
        tick();
        do_dump();
        wait_valid();
        check("single_acc", 32'(acc_out),    32'd65025);
        check("single_cnt", 32'(prod_count), 32'd1);
        check("single_ovf", 32'(overflow),   32'd0);
        handshake();
        check("single_cnt_clr", 32'(prod_count), 32'd0);
        check("single_valid_lo", 32'(out_valid), 32'd0);

        // Dump with empty FIFO: EMIT one cycle after DRAIN, total 0
        do_dump();
        check("empty_dump_drain", 32'(out_valid), 32'd0);
        tick();
        check("empty_dump_emit", 32'(out_valid), 32'd1);
        check("empty_dump_acc",  32'(acc_out),   32'd0);
        handshake();

        // Burst of three back-to-back products
        prod_valid = 1'b1;
        prod = 16'd65025; tick();
        prod = 16'd961;   tick();
        prod = 16'd1;     tick();
        prod_valid = 1'b0;
        do_dump();
        wait_valid();
        check("burst_acc", 32'(acc_out),    32'd65987);
        check("burst_cnt", 32'(prod_count), 32'd3);
        handshake();

        // 258 products stay just below saturation
        prod_valid = 1'b1; prod = 16'd65025;
        for (int i = 0; i < 258; i++) tick();
        prod_valid = 1'b0;
        do_dump();
        wait_valid();
        check("sat258_acc", 32'(acc_out),    32'd16776450);
        check("sat258_ovf", 32'(overflow),   32'd0);
        check("sat258_cnt", 32'(prod_count), 32'd255);
        handshake();

        // 259 products saturate
        prod_valid = 1'b1; prod = 16'd65025;
        for (int i = 0; i < 259; i++) tick();
        prod_valid = 1'b0;
        do_dump();
        wait_valid();
        check("sat259_acc", 32'(acc_out),    32'd16777215);
        check("sat259_ovf", 32'(overflow),   32'd1);
        check("sat259_cnt", 32'(prod_count), 32'd255);
        handshake();
        check("sat_ovf_clr", 32'(overflow), 32'd0);

        // FIFO full during EMIT: five pushes, four kept
        prod_valid = 1'b1;
        prod = 16'd10; tick();
        prod = 16'd20; dump = 1'b1; tick();
        prod_valid = 1'b0; dump = 1'b0;
        wait_valid();
        check("full_pre_acc", 32'(acc_out), 32'd30);
        for (int i = 1; i <= 5; i++) push(PW'(i * 100));
        check("full_dropped", 32'(dropped), 32'd1);
        check("full_acc_hold", 32'(acc_out), 32'd30);
        check("full_busy", 32'(busy), 32'd1);
        handshake();
        push(16'd7);
        for (int i = 0; i < 5; i++) tick();
        do_dump();
        wait_valid();
        check("full_sum", 32'(acc_out),    32'd1007);
        check("full_cnt", 32'(prod_count), 32'd5);
        check("full_drop_sticky", 32'(dropped), 32'd1);
        handshake();

        // Clear during EMIT, with a coincident push that must be discarded
        push(16'd42);
        do_dump();
        wait_valid();
        check("clr_pre_acc", 32'(acc_out), 32'd42);
        clr = 1'b1; prod_valid = 1'b1; prod = 16'd99;
        tick();
        clr = 1'b0; prod_valid = 1'b0;
        check("clr_valid", 32'(out_valid),  32'd0);
        check("clr_cnt",   32'(prod_count), 32'd0);
        check("clr_drop",  32'(dropped),    32'd0);
        check("clr_busy",  32'(busy),       32'd0);
        tick();
        do_dump();
        wait_valid();
        check("clr_acc_zero", 32'(acc_out), 32'd0);
        handshake();

        // Reset in the middle of DRAIN with three entries queued
        do_dump();
        wait_valid();
        push(16'd1); push(16'd2); push(16'd3);
        out_ready = 1'b1; push(16'd4); out_ready = 1'b0;
        do_dump();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_valid", 32'(out_valid),  32'd0);
        check("rst_mid_busy",  32'(busy),       32'd0);
        check("rst_mid_cnt",   32'(prod_count), 32'd0);
        check("rst_mid_acc",   32'(acc_out),    32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy",  32'(busy),      32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
